h_row_source: RTL and testbench
===============================

H_ROW_SOURCE -- requirements
Module: h_row_source

Interface
REQ-001 Parameter J, default 14: rows per H frame.
REQ-002 Parameter I, default 7: elements per H row.
REQ-003 Parameter A, default 2: passes of the full frame per start.
REQ-004 Parameter W, default 1: bits per H element.
REQ-005 Derived constants: J_WIDTH = $clog2(J)+1, I_WIDTH = $clog2(I)+1, A_WIDTH = $clog2(A)+1.
REQ-006 clk  in  1  single clock; all logic rises on posedge clk.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle launch request.
REQ-009 wr_en  in  1  row write strobe into the write bank.
REQ-010 wr_addr  in  J_WIDTH  row index 0..J-1.
REQ-011 wr_data  in  I*W  row payload; element k occupies bits [k*W +: W].
REQ-012 commit  in  1  swap write and read banks.
REQ-013 H_row  out  I*W  streamed row.
REQ-014 H_row_tvalid  out  1  row valid.
REQ-015 H_row_tready  in  1  downstream ready.
REQ-016 H_row_tlast  out  1  high on row J-1 of every pass.
REQ-017 pass_idx  out  A_WIDTH  current pass, 0..A-1.
REQ-018 busy  out  1  high while the FSM is in STREAM.
REQ-019 done  out  1  one-cycle pulse after the final beat.

Function
REQ-020 Storage SHALL be two banks of J rows each; bank_sel selects the read bank and !bank_sel the write bank.
REQ-021 wr_en with wr_addr < J SHALL write wr_data into the write bank at the next edge; wr_addr >= J SHALL be ignored; writes SHALL be accepted in every state.
REQ-022 The FSM SHALL have states IDLE, STREAM, and DONE.
REQ-023 IDLE: start SHALL load row=0 and pass=0 and enter STREAM; H_row_tvalid SHALL rise on the edge that samples start, i.e. 1-cycle latency.
REQ-024 STREAM: H_row, tlast, and pass_idx SHALL be registered and held stable while tvalid=1 and tready=0.
REQ-025 A beat SHALL complete only when tvalid and tready are both high; with tready held high the block SHALL emit one row per cycle.
REQ-026 At the handshake, row SHALL advance; at row J-1 it SHALL wrap to 0 and pass SHALL increment.
REQ-027 The handshake of row J-1 in pass A-1 SHALL drop tvalid and enter DONE.
REQ-028 DONE: done=1 for exactly one cycle, then the FSM returns to IDLE; total beats per start = J*A (28 by default).
REQ-029 start while in STREAM or DONE SHALL be ignored and not queued.
REQ-030 commit in IDLE SHALL toggle bank_sel at the next edge.
REQ-031 commit in STREAM or DONE SHALL set commit_pend; the toggle SHALL happen on entry to IDLE, so the read bank never changes mid-stream.
REQ-032 commit and start in the same IDLE cycle: the toggle takes effect first and the stream SHALL read the newly committed bank.
REQ-033 wr_en and commit in the same cycle: the write SHALL land in the pre-swap write bank.
REQ-034 Row data SHALL be read combinationally from the read bank and registered into H_row on load and after each handshake.

Reset
REQ-035 rst_n low SHALL immediately force: state=IDLE, H_row=0, H_row_tvalid=0, H_row_tlast=0, pass_idx=0, busy=0, done=0, bank_sel=0, commit_pend=0, row/pass counters=0.
REQ-036 Bank storage SHALL NOT be reset; its contents are undefined until written.
REQ-037 Reset asserted mid-stream SHALL abort the frame with no done pulse; after release the block SHALL wait in IDLE for start.

Structure
REQ-038 A shared package h_row_pkg SHALL hold the defaults for J, I, A, and W, the derived *_WIDTH constants, and the state enum {IDLE, STREAM, DONE}.
REQ-039 Storage SHALL be a sub-module h_row_bank (two banks, one write port, one combinational read port, bank_sel input); the FSM, counters, and output registers SHALL live in h_row_source.

Verification
REQ-040 Load rows r=0..13 with value r+1 into the write bank, commit, start with tready=1 -> tvalid high for 28 consecutive cycles; H_row = 1..14 in each pass; tlast on beats 14 and 28; pass_idx 0 then 1; done 1 cycle after beat 28.
REQ-041 As REQ-040 with tready toggling 1,0,1,0 -> 28 beats in order, H_row stable during every stall, done only after the 28th handshake.
REQ-042 Write bank B with rows = 0x7F and commit during STREAM -> all 28 beats still carry the bank A data; bank_sel toggles at entry to IDLE; next start streams 0x7F.
REQ-043 Start pulsed at beat 5 of a stream -> ignored; still exactly 28 beats and one done pulse.
REQ-044 rst_n low at beat 10 -> tvalid=0 and all outputs 0 immediately, no done; start after release -> full 28-beat frame from row 0, bank_sel=0.
REQ-045 wr_addr=14 with wr_en=1 -> no row changes; start and commit in the same cycle -> the stream carries the newly committed bank.

Source files
------------

// File: rtl/h_row_pkg.sv
// Shared defaults, derived widths and FSM state type for the H row source.
package h_row_pkg;

  localparam int unsigned J_DEF = 14;
  localparam int unsigned I_DEF = 7;
  localparam int unsigned A_DEF = 2;
  localparam int unsigned W_DEF = 1;

  localparam int unsigned J_WIDTH_DEF = $clog2(J_DEF) + 1;
  localparam int unsigned I_WIDTH_DEF = $clog2(I_DEF) + 1;
  localparam int unsigned A_WIDTH_DEF = $clog2(A_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/h_row_bank.sv
// Double-banked row storage: one write port into !bank_sel, one combinational read port.
module h_row_bank
  import h_row_pkg::*;
#(
  parameter int unsigned J       = J_DEF,
  parameter int unsigned I       = I_DEF,
  parameter int unsigned W       = W_DEF,
  parameter int unsigned J_WIDTH = $clog2(J) + 1,
  parameter int unsigned AW      = (J > 1) ? $clog2(J) : 1
) (
  input  logic               clk,
  input  logic               bank_sel,
  input  logic               wr_en,
  input  logic [J_WIDTH-1:0] wr_addr,
  input  logic [I*W-1:0]     wr_data,
  input  logic               rd_bank,
  input  logic [AW-1:0]      rd_addr,
  output logic [I*W-1:0]     rd_data
);

  logic [I*W-1:0] mem0 [J];
  logic [I*W-1:0] mem1 [J];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < J_WIDTH'(J))) begin
      if (bank_sel) mem0[wr_addr[AW-1:0]] <= wr_data;
      else          mem1[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = rd_bank ? mem1[rd_addr] : mem0[rd_addr];

endmodule

// File: rtl/h_row_source.sv
// Streams J rows of the committed H bank, A passes per start, over a valid/ready port.
module h_row_source
  import h_row_pkg::*;
#(
  parameter int unsigned J = J_DEF,
  parameter int unsigned I = I_DEF,
  parameter int unsigned A = A_DEF,
  parameter int unsigned W = W_DEF,
  localparam int unsigned J_WIDTH = $clog2(J) + 1,
  localparam int unsigned I_WIDTH = $clog2(I) + 1,
  localparam int unsigned A_WIDTH = $clog2(A) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               wr_en,
  input  logic [J_WIDTH-1:0] wr_addr,
  input  logic [I*W-1:0]     wr_data,
  input  logic               commit,
  output logic [I*W-1:0]     H_row,
  output logic               H_row_tvalid,
  input  logic               H_row_tready,
  output logic               H_row_tlast,
  output logic [A_WIDTH-1:0] pass_idx,
  output logic               busy,
  output logic               done
);

  localparam int unsigned AW = (J > 1) ? $clog2(J) : 1;

  state_t             state, state_nxt;
  logic [J_WIDTH-1:0] row_cnt, row_nxt;
  logic [A_WIDTH-1:0] pass_cnt, pass_nxt;
  logic               bank_sel, bank_sel_nxt;
  logic               commit_pend, commit_pend_nxt;
  logic [I*W-1:0]     h_row_nxt;
  logic               tvalid_nxt, tlast_nxt, busy_nxt, done_nxt;
  logic [A_WIDTH-1:0] pass_idx_nxt;
  logic               load_c;
  logic [I*W-1:0]     rd_data_c;

  h_row_bank #(
    .J       (J),
    .I       (I),
    .W       (W),
    .J_WIDTH (J_WIDTH),
    .AW      (AW)
  ) u_bank (
    .clk      (clk),
    .bank_sel (bank_sel),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_bank  (bank_sel_nxt),
    .rd_addr  (row_nxt[AW-1:0]),
    .rd_data  (rd_data_c)
  );

  // Reading through bank_sel_nxt lets a start in the commit cycle see the new bank.
  always_comb begin
    state_nxt       = state;
    row_nxt         = row_cnt;
    pass_nxt        = pass_cnt;
    bank_sel_nxt    = bank_sel;
    commit_pend_nxt = commit_pend;
    tvalid_nxt      = H_row_tvalid;
    done_nxt        = 1'b0;
    load_c          = 1'b0;
    unique case (state)
      IDLE: begin
        if (commit) bank_sel_nxt = ~bank_sel;
        if (start) begin
          state_nxt  = STREAM;
          row_nxt    = '0;
          pass_nxt   = '0;
          tvalid_nxt = 1'b1;
          load_c     = 1'b1;
        end
      end
      STREAM: begin
        if (commit) commit_pend_nxt = 1'b1;
        if (H_row_tvalid && H_row_tready) begin
          if (row_cnt == J_WIDTH'(J - 1)) begin
            if (pass_cnt == A_WIDTH'(A - 1)) begin
              state_nxt  = DONE;
              tvalid_nxt = 1'b0;
              done_nxt   = 1'b1;
            end else begin
              row_nxt  = '0;
              pass_nxt = pass_cnt + A_WIDTH'(1);
              load_c   = 1'b1;
            end
          end else begin
            row_nxt = row_cnt + J_WIDTH'(1);
            load_c  = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt       = IDLE;
        bank_sel_nxt    = bank_sel ^ (commit_pend | commit);
        commit_pend_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase

    h_row_nxt    = load_c ? rd_data_c : H_row;
    tlast_nxt    = load_c ? (row_nxt == J_WIDTH'(J - 1)) : (H_row_tlast & tvalid_nxt);
    pass_idx_nxt = load_c ? pass_nxt : pass_idx;
    busy_nxt     = (state_nxt == STREAM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      row_cnt      <= '0;
      pass_cnt     <= '0;
      bank_sel     <= 1'b0;
      commit_pend  <= 1'b0;
      H_row        <= '0;
      H_row_tvalid <= 1'b0;
      H_row_tlast  <= 1'b0;
      pass_idx     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      row_cnt      <= row_nxt;
      pass_cnt     <= pass_nxt;
      bank_sel     <= bank_sel_nxt;
      commit_pend  <= commit_pend_nxt;
      H_row        <= h_row_nxt;
      H_row_tvalid <= tvalid_nxt;
      H_row_tlast  <= tlast_nxt;
      pass_idx     <= pass_idx_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
    end
  end

endmodule

// File: tb/tb_h_row_source.sv
// Self-checking bench for h_row_source against a frame-level bank/beat model.
module tb_h_row_source;

  localparam int unsigned J = 14;
  localparam int unsigned I = 7;
  localparam int unsigned A = 2;
  localparam int unsigned W = 1;
  localparam int unsigned BEATS = J * A;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start, wr_en, commit, tready;
  logic [4:0]     wr_addr;
  logic [I*W-1:0] wr_data;
  logic [I*W-1:0] h_row;
  logic           tvalid, tlast, busy, done;
  logic [1:0]     pass_idx;

  int checks = 0;
  int failures = 0;

  logic [I*W-1:0] exp_bank [2][J];
  bit             m_sel;
  bit             m_pend;

  h_row_source #(.J(J), .I(I), .A(A), .W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .commit       (commit),
    .H_row        (h_row),
    .H_row_tvalid (tvalid),
    .H_row_tready (tready),
    .H_row_tlast  (tlast),
    .pass_idx     (pass_idx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_tvalid"}, 32'(tvalid), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // One-cycle row write (optionally with commit in the same cycle), applied to the model.
  task automatic write_row(input int addr, input logic [I*W-1:0] d, input bit with_commit);
    wr_en = 1'b1; wr_addr = 5'(addr); wr_data = d; commit = with_commit;
    @(negedge clk);
    wr_en = 1'b0; commit = 1'b0;
    if (addr < J) exp_bank[m_sel ? 0 : 1][addr] = d;
    if (with_commit) m_sel = ~m_sel;
  endtask

  task automatic commit_idle();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    m_sel = ~m_sel;
  endtask

  // mode: 0 always ready, 1 alternating, 2 random. rst_beat < 0 means no reset.
  task automatic run_frame(input int mode, input bit start_mid, input bit wr_mid,
                           input bit cm_mid, input int rst_beat, input bit cm_start);
    int beat = 0;
    int cyc = 0;
    bit rdy;
    bit alt = 1'b1;
    int row;
    chk_idle_outputs("pre_start");
    start = 1'b1; commit = cm_start;
    if (cm_start) m_sel = ~m_sel;
    @(negedge clk);
    start = 1'b0; commit = 1'b0;
    while (beat < BEATS && cyc < 400) begin
      if (rst_beat == beat) begin
        rst_n = 1'b0;
        #1;
        chk("rst_tvalid", 32'(tvalid), 0);
        chk("rst_hrow", 32'(h_row), 0);
        chk("rst_tlast", 32'(tlast), 0);
        chk("rst_pass", 32'(pass_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_sel = 1'b0; m_pend = 1'b0; tready = 1'b0;
        return;
      end
      row = beat % J;
      chk("tvalid", 32'(tvalid), 1);
      chk("h_row", 32'(h_row), 32'(exp_bank[m_sel][row]));
      chk("tlast", 32'(tlast), 32'(row == J - 1));
      chk("pass_idx", 32'(pass_idx), 32'(beat / J));
      chk("busy", 32'(busy), 1);
      chk("done_early", 32'(done), 0);
      case (mode)
        0:       rdy = 1'b1;
        1:       begin rdy = alt; alt = ~alt; end
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      tready = rdy; wr_en = 1'b0; commit = 1'b0; start = 1'b0;
      if (wr_mid && cyc < J) begin
        wr_en = 1'b1; wr_addr = 5'(cyc); wr_data = 7'h7F;
        exp_bank[m_sel ? 0 : 1][cyc] = 7'h7F;
      end
      if (cm_mid && cyc == 15) begin commit = 1'b1; m_pend = 1'b1; end
      if (start_mid && beat == 5) start = 1'b1;
      @(negedge clk);
      if (rdy) beat++;
      cyc++;
    end
    tready = 1'b0; wr_en = 1'b0; commit = 1'b0; start = 1'b0;
    chk("frame_beats", 32'(beat), 32'(BEATS));
    chk("done_pulse", 32'(done), 1);
    chk("tvalid_end", 32'(tvalid), 0);
    chk("busy_end", 32'(busy), 0);
    if (m_pend) m_sel = ~m_sel;
    m_pend = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("tvalid_idle", 32'(tvalid), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; wr_en = 1'b0; commit = 1'b0; tready = 1'b0;
    wr_addr = '0; wr_data = '0; m_sel = 1'b0; m_pend = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_hrow", 32'(h_row), 0);
    chk("reset_pass", 32'(pass_idx), 0);
    chk("reset_tlast", 32'(tlast), 0);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Rows r+1; last write shares its cycle with commit and must land pre-swap.
    for (int r = 0; r < J; r++) write_row(r, 7'(r + 1), r == J - 1);
    run_frame(0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    run_frame(1, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    // Fill the other bank with 0x7F and commit mid-stream; next frame shows it.
    run_frame(0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    run_frame(2, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    // Start mid-stream is ignored.
    run_frame(2, 1'b1, 1'b0, 1'b0, -1, 1'b0);

    // Flip to bank 1, then reset mid-frame: reset must restore bank 0.
    commit_idle();
    run_frame(0, 1'b0, 1'b0, 1'b0, 10, 1'b0);
    chk_idle_outputs("post_rst");
    repeat (3) @(negedge clk);
    chk_idle_outputs("post_rst_wait");
    run_frame(0, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    // Out-of-range write ignored; commit with start streams the new bank.
    write_row(J, 7'($urandom), 1'b0);
    for (int r = 0; r < J; r++) write_row(r, 7'($urandom), 1'b0);
    write_row(J, 7'($urandom), 1'b0);
    run_frame(2, 1'b0, 1'b0, 1'b0, -1, 1'b1);

    for (int r = 0; r < J; r++) write_row(r, 7'($urandom), 1'b0);
    commit_idle();
    run_frame(2, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
